// File: rtl/noc_input_buffer.sv
// noc_input_buffer
//   Per-port flit input buffer on the receive side of a NoC link. Stores incoming flits in a
//   DEPTH-entry circular FIFO and presents the oldest flit to the route/crossbar stage. Each
//   accepted pop produces a registered one-cycle credit pulse for the upstream credit counter.
//   Link-side head/body/tail framing is checked, and overflow and framing errors are flagged.
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   flit_valid_i     link flit present
//   flit_data_i      link flit payload
//   flit_type_i      00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL
//   pop_i            crossbar consumes the front flit
//   flit_valid_o     FIFO non-empty
//   flit_data_o      front flit payload (don't-care when empty)
//   flit_type_o      front flit type (don't-care when empty)
//   head_valid_o     front flit opens a packet (HEAD or HEADTAIL)
//   credit_return_o  one-cycle pulse per accepted pop
//   count_o          occupancy 0..DEPTH
//   overflow_o       sticky: flit arrived while full
//   protocol_err_o   sticky: framing violation on input

module noc_input_buffer #(
    parameter int unsigned FLIT_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flit_valid_i,
    input  logic [FLIT_W-1:0]        flit_data_i,
    input  logic [1:0]               flit_type_i,
    input  logic                     pop_i,
    output logic                     flit_valid_o,
    output logic [FLIT_W-1:0]        flit_data_o,
    output logic [1:0]               flit_type_o,
    output logic                     head_valid_o,
    output logic                     credit_return_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     protocol_err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] TypeBody     = 2'b00;
    localparam logic [1:0] TypeHead     = 2'b01;
    localparam logic [1:0] TypeTail     = 2'b10;
    localparam logic [1:0] TypeHeadTail = 2'b11;

    typedef enum logic {StIdle, StInPkt} frame_state_e;

    logic [FLIT_W+1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              credit_q;
    logic              overflow_q, overflow_d;
    logic              perr_q, perr_d;
    frame_state_e      state_q, state_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [FLIT_W+1:0] front;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop on a full FIFO frees the slot the same edge, so the push is still accepted.
    assign pop  = pop_i && !empty;
    assign push = flit_valid_i && (!full || pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (flit_valid_i && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Framing is checked on every link flit, whether or not it is stored.
    always_comb begin
        state_d = state_q;
        perr_d  = perr_q;

        if (flit_valid_i) begin
            unique case (state_q)
                StIdle: begin
                    unique case (flit_type_i)
                        TypeHead:     state_d = StInPkt;
                        TypeHeadTail: state_d = StIdle;
                        default:      perr_d  = 1'b1;
                    endcase
                end
                StInPkt: begin
                    unique case (flit_type_i)
                        TypeBody: state_d = StInPkt;
                        TypeTail: state_d = StIdle;
                        TypeHead: begin
                            perr_d  = 1'b1;
                            state_d = StInPkt;
                        end
                        TypeHeadTail: begin
                            perr_d  = 1'b1;
                            state_d = StIdle;
                        end
                        default: state_d = StInPkt;
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
            state_q    <= StIdle;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            credit_q   <= pop;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {flit_type_i, flit_data_i};
        end
    end

    assign front           = mem_q[rptr_q];
    assign flit_valid_o    = !empty;
    assign flit_data_o     = front[FLIT_W-1:0];
    assign flit_type_o     = front[FLIT_W+1:FLIT_W];
    assign head_valid_o    = flit_valid_o && flit_type_o[0];
    assign credit_return_o = credit_q;
    assign count_o         = count_q;
    assign overflow_o      = overflow_q;
    assign protocol_err_o  = perr_q;

endmodule

// File: doc/noc_input_buffer.md
# noc_input_buffer

Per-port flit input buffer for the NoC router, sitting on the receive side of a link and directly downstream of the upstream router's credit counter. It stores incoming flits in a DEPTH-entry FIFO and presents the oldest flit to the local route/crossbar stage. Every flit it releases produces a one-cycle credit-return pulse that drives the upstream counter's `incr_i`. It also checks the head/body/tail packet framing on the link side and flags overflow and framing errors.

## Interface
Parameters:
- `FLIT_W`, 32: flit payload width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2; equals the upstream counter's initial credit count.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flit_valid_i`  in  1  link flit present this cycle.
- `flit_data_i`  in  FLIT_W  link flit payload.
- `flit_type_i`  in  2  flit type: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL (single-flit packet).
- `pop_i`  in  1  crossbar consumes the front flit this cycle.
- `flit_valid_o`  out  1  FIFO non-empty.
- `flit_data_o`  out  FLIT_W  front flit payload.
- `flit_type_o`  out  2  front flit type.
- `head_valid_o`  out  1  front flit is HEAD or HEADTAIL; route computation may start.
- `credit_return_o`  out  1  one-cycle pulse per accepted pop; connects to upstream `incr_i`.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_o`  out  1  sticky: a flit arrived while full.
- `protocol_err_o`  out  1  sticky: framing violation on input.

## Operation
- Storage: circular FIFO with write pointer, read pointer, and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally. full = (count == DEPTH). empty = (count == 0).
- Push: `flit_valid_i` and not full writes {type, data} at wptr, then wptr++. Push when full: the flit is dropped and `overflow_o` is set.
- Simultaneous push and pop while full: the push is accepted, because the pop frees a slot in the same edge. count is unchanged.
- Pop: `pop_i` and not empty advances rptr. Pop when empty is ignored: no pointer change, no credit pulse.
- Simultaneous push and pop while empty: the push is accepted and the pop is ignored. There is no bypass path.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Outputs `flit_data_o` and `flit_type_o` read combinationally from the entry at rptr. They are don't-care when empty.
- `head_valid_o` = `flit_valid_o` & `flit_type_o`[0].
- Framing FSM, evaluated on every input flit including dropped ones:
  - IDLE: HEAD → IN_PKT; HEADTAIL → IDLE; BODY or TAIL → set `protocol_err_o`, stay in IDLE.
  - IN_PKT: BODY → IN_PKT; TAIL → IDLE; HEAD or HEADTAIL → set `protocol_err_o`; HEAD stays in IN_PKT, HEADTAIL goes to IDLE.
  - Erroneous flits are still stored if space exists.
- Sticky flags clear only on reset.

## Timing
- Reset (rst = 0, asynchronous) sets:
  - pointers and count to 0, FSM to IDLE;
  - `flit_valid_o`, `head_valid_o`, `credit_return_o`, `overflow_o`, `protocol_err_o` all 0;
  - `count_o` = 0.
- Reset release is synchronous to `clk` at the system level.
- Reset mid-packet discards all stored flits. No credit pulses are issued for discarded flits; the upstream counter is reset concurrently.
- Write latency: a flit pushed at edge N is visible on `flit_valid_o` and `flit_data_o` after edge N (cycle N+1).
- Credit latency: a pop accepted at edge N drives `credit_return_o` = 1 for exactly the cycle after edge N. The output is registered, and back-to-back pops give back-to-back pulses.
- `count_o`, `overflow_o`, and `protocol_err_o` are registered and update one edge after the causing event.
- Credit invariant: the number of credit pulses equals the number of accepted pops. With a correctly sized upstream counter, `overflow_o` never asserts.

## Test plan
- Reset then idle → all outputs 0, `count_o` = 0. Assert rst low mid-operation with count = 3 → `count_o` = 0 and `flit_valid_o` = 0 immediately, without waiting for a clock edge.
- DEPTH = 4: push HEAD 0xA0, BODY 0xA1, BODY 0xA2, TAIL 0xA3 → `count_o` = 4, `head_valid_o` = 1 with `flit_data_o` = 0xA0. Four pops → data out 0xA0..0xA3 in order, four single-cycle `credit_return_o` pulses each one cycle after its pop, `count_o` = 0.
- Full (count = 4): push 0xBB with no pop → dropped, `overflow_o` = 1, count stays 4. Full: push plus pop in the same cycle → count stays 4, the new flit is read last, one credit pulse.
- Empty: `pop_i` = 1 for 3 cycles → no credit pulses, count stays 0. Empty: push plus pop in the same cycle → count = 1, no credit pulse.
- Framing: BODY while IDLE → `protocol_err_o` = 1 and the flit is still stored. HEAD, then HEAD → error. HEADTAIL, then HEAD → no error.
- Wrap-around: run 10 push/pop cycles interleaved with random stalls → in-order data, pointers wrap twice, total credit pulses = total pops.
